seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the stopwatch's multiplexed 7-segment display driver.
- Samples the active-low anode-select and segment buses and decodes each stable segment pattern back to a BCD digit.
- Reassembles the four digits of one scan into an atomically updated mm:ss time value.
- Used for on-board display readback and as a self-check monitor in system benches.

Parameters:
SETTLE_CYCLES, 16, consecutive identical synchronized samples required before a digit is captured (>=2)
TIMEOUT_CYCLES, 500000, cycles without any capture before stale asserts and frame tracking resynchronizes

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
illuminate_in  input  8  active-low anode select; 8'hFE=digit0, 8'hFD=digit1, 8'hEF=digit2, 8'hDF=digit3
segment_in  input  8  active-low segments {a,b,c,d,e,f,g,dp}, a at bit 7
capture_en  input  1  enables capture; low holds the FSM in SYNC
units_seconds  output  4  published digit0
tens_seconds  output  4  published digit1
units_minutes  output  4  published digit2
tens_minutes  output  4  published digit3
frame_done  output  1  one-cycle pulse when a new frame is published
pattern_error  output  1  sticky; an unrecognized segment pattern was captured
seq_error  output  1  sticky; a digit was captured out of scan order
stale  output  1  no capture within TIMEOUT_CYCLES

Behaviour:
- Reset: clk and reset are as specified above: reset is asynchronous and active-high, and clk is the clock. During reset:
  - Both 2-flop synchronizers load 8'hFF.
  - All outputs, shadow digits and counters clear to 0.
  - The FSM enters SYNC.
- Input path: 2-flop synchronizer on both buses, then a registered previous-sample copy.
- Stable counter:
  - Increments, saturating at SETTLE_CYCLES, while {illum, seg} equals the previous sample.
  - Clears to 0 on any difference.
- Capture strobe: one cycle, issued exactly when the stable counter first reaches SETTLE_CYCLES. At most one capture per stable period.
- Capture is suppressed when capture_en=0 or the anode value is not one of the four listed codes (including 8'hFF and multi-hot values). A suppressed capture has no error effect.
- Segment decode uses bits [7:1] only; dp is ignored. Table for {a..g}, values in hex:
  - 0 to 4: 01, 4F, 12, 06, 4C
  - 5 to 9: 24, 20, 0F, 00, 04
  - Any other pattern, including blank 7F: decodes to 4'hF and sets pattern_error on capture.
- Each capture writes the decoded value into shadow[digit] in the cycle after the strobe.
- FSM states: SYNC, EXP1, EXP2, EXP3 (expected next digit). Each capture is handled as follows:
  - Digit0 capture, from any state: go to EXP1. If the state was EXP2 or EXP3, also set seq_error.
  - Expected digit in EXP1 or EXP2: advance to the next EXP state.
  - Digit3 captured in EXP3: publish shadow0..3 to the outputs (the digit3 value is forwarded in the same update), pulse frame_done, go to SYNC.
  - Re-capture of the most recently captured digit (segment change within one anode slot): update its shadow only, with no state change and no error.
  - Any other digit captured in EXP1..EXP3: set seq_error, go to SYNC.
  - Any digit other than 0 captured in SYNC: ignored, no error.
- Latency: frame_done and the new output values appear 1 cycle after the digit3 capture strobe. That is SETTLE_CYCLES+3 clocks after the last digit3 input change.
- Outputs hold between frames; a partial frame never changes them.
- Timeout counter:
  - Clears on every capture, and is held at 0 while capture_en=0.
  - On reaching TIMEOUT_CYCLES, stale is set and the FSM returns to SYNC; the counter saturates.
  - stale clears on the next capture.
- capture_en deasserted mid-frame: FSM goes to SYNC next cycle and shadows are retained. Outputs, pattern_error and seq_error hold.
- Reset asserted mid-frame: immediate return to the reset state; no frame_done pulse.

Test Plan:
1. Scan 12:34 (digit0..3 = 4,3,2,1 patterns 4C,06,12,4F, dp=1), 100-cycle dwell per digit, SETTLE_CYCLES=16 -> frame_done after digit3 settles; outputs 4,3,2,1; no errors.
2. Scan order digit0, digit2 -> seq_error=1, FSM in SYNC, no frame_done. A subsequent clean scan of 05:59 -> frame_done, outputs 9,5,5,0.
3. Digit2 segment 7F (blank) inside an otherwise valid scan -> pattern_error=1, units_minutes=4'hF at frame_done.
4. Glitch: segment toggles every 10 cycles within an anode slot (< SETTLE_CYCLES) -> no capture; outputs unchanged.
5. Anode held at 8'hFF for TIMEOUT_CYCLES (bench override 1000) -> stale=1 at cycle 1000. The next valid digit0 capture clears stale.
6. Reset pulse during EXP2 -> all outputs 0, errors cleared. The next full scan of 00:07 publishes 7,0,0,0.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//
// Receive-side decoder for a multiplexed, active-low 7-segment display bus.
// It watches the anode-select and segment lines, waits for each digit slot to
// settle, and turns the segment pattern back into a BCD digit. The four digits
// of one scan are collected in shadow registers. They are then published
// together as an mm:ss value, so a reader never sees a half-updated time.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   illuminate_in  [7:0] active-low anode select
//                  (8'hFE=digit0, 8'hFD=digit1, 8'hEF=digit2, 8'hDF=digit3)
//   segment_in     [7:0] active-low segments {a,b,c,d,e,f,g,dp}
//   capture_en     enables capture; low parks the frame tracker in SYNC
//   units_seconds  [3:0] published digit0
//   tens_seconds   [3:0] published digit1
//   units_minutes  [3:0] published digit2
//   tens_minutes   [3:0] published digit3
//   frame_done     one-cycle pulse when a new frame is published
//   pattern_error  sticky: an unrecognised segment pattern was captured
//   seq_error      sticky: a digit was captured out of scan order
//   stale          no capture seen within TIMEOUT_CYCLES
//   fsm_state      [1:0] frame tracker state (0=SYNC, 1..3=EXP1..EXP3)
//
// Parameters
//   SETTLE_CYCLES  identical consecutive samples needed before a capture (>=2)
//   TIMEOUT_CYCLES cycles without a capture before stale asserts

module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] illuminate_in,
  input  logic [7:0] segment_in,
  input  logic       capture_en,
  output logic [3:0] units_seconds,
  output logic [3:0] tens_seconds,
  output logic [3:0] units_minutes,
  output logic [3:0] tens_minutes,
  output logic       frame_done,
  output logic       pattern_error,
  output logic       seq_error,
  output logic       stale,
  output logic [1:0] fsm_state
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_MAX   = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    EXP1 = 2'd1,
    EXP2 = 2'd2,
    EXP3 = 2'd3
  } state_t;

  // Input path: two-flop synchronizers plus a previous-sample copy.
  logic [7:0] illum_s1, illum_s2, illum_p;
  logic [7:0] seg_s1, seg_s2, seg_p;

  logic [SW-1:0] stable_cnt;
  logic [TW-1:0] to_cnt;

  state_t     state;
  logic [3:0] shadow [4];

  logic       sample_same;
  logic       anode_ok;
  logic [1:0] cap_digit;
  logic [3:0] cap_val;
  logic       cap_stb;
  logic       timeout_hit;

  assign fsm_state = state;

  // ------------------------------------------------------------------
  // Combinational decode of the synchronized sample
  // ------------------------------------------------------------------
  always_comb begin
    sample_same = (illum_s2 == illum_p) && (seg_s2 == seg_p);

    // Only one-hot-low anode codes for the four used slots are accepted.
    // Blanking (8'hFF) and overlapped selects fall into the default arm.
    anode_ok  = 1'b1;
    cap_digit = 2'd0;
    case (illum_s2)
      8'hFE:   cap_digit = 2'd0;
      8'hFD:   cap_digit = 2'd1;
      8'hEF:   cap_digit = 2'd2;
      8'hDF:   cap_digit = 2'd3;
      default: anode_ok  = 1'b0;
    endcase

    // Segment decode over {a..g}. The decimal point is not part of the digit.
    case (seg_s2[7:1])
      7'h01:   cap_val = 4'd0;
      7'h4F:   cap_val = 4'd1;
      7'h12:   cap_val = 4'd2;
      7'h06:   cap_val = 4'd3;
      7'h4C:   cap_val = 4'd4;
      7'h24:   cap_val = 4'd5;
      7'h20:   cap_val = 4'd6;
      7'h0F:   cap_val = 4'd7;
      7'h00:   cap_val = 4'd8;
      7'h04:   cap_val = 4'd9;
      default: cap_val = 4'hF;
    endcase

    // The strobe is asserted in the cycle where the counter steps from
    // SETTLE-1 to SETTLE. Once the counter saturates, this term cannot
    // become true again until the bus changes. That limits each stable
    // period to one capture.
    cap_stb = capture_en && anode_ok && sample_same && (stable_cnt == SETTLE_LAST);

    timeout_hit = capture_en && !cap_stb && (to_cnt == TIMEOUT_LAST);
  end

  // ------------------------------------------------------------------
  // Input path, settle counter, timeout counter
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illum_s1   <= 8'hFF;
      illum_s2   <= 8'hFF;
      illum_p    <= 8'hFF;
      seg_s1     <= 8'hFF;
      seg_s2     <= 8'hFF;
      seg_p      <= 8'hFF;
      stable_cnt <= '0;
      to_cnt     <= '0;
    end else begin
      illum_s1 <= illuminate_in;
      illum_s2 <= illum_s1;
      illum_p  <= illum_s2;
      seg_s1   <= segment_in;
      seg_s2   <= seg_s1;
      seg_p    <= seg_s2;

      if (!sample_same) begin
        stable_cnt <= '0;
      end else if (stable_cnt != SETTLE_MAX) begin
        stable_cnt <= stable_cnt + 1'b1;
      end

      if (!capture_en || cap_stb) begin
        to_cnt <= '0;
      end else if (to_cnt != TIMEOUT_MAX) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Frame tracker FSM with shadow digits and registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= SYNC;
      for (int i = 0; i < 4; i++) shadow[i] <= 4'd0;
      units_seconds <= 4'd0;
      tens_seconds  <= 4'd0;
      units_minutes <= 4'd0;
      tens_minutes  <= 4'd0;
      frame_done    <= 1'b0;
      pattern_error <= 1'b0;
      seq_error     <= 1'b0;
      stale         <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (!capture_en) begin
        // Shadows, outputs and sticky flags are all kept. Only the frame
        // alignment is dropped.
        state <= SYNC;
      end else if (cap_stb) begin
        shadow[cap_digit] <= cap_val;
        stale             <= 1'b0;
        if (cap_val == 4'hF) pattern_error <= 1'b1;

        if (cap_digit == 2'd0) begin
          // digit0 always starts a new frame. Abandoning a frame that had
          // already advanced past digit1 counts as an ordering error.
          if (state == EXP2 || state == EXP3) seq_error <= 1'b1;
          state <= EXP1;
        end else begin
          case (state)
            SYNC: begin
              // Wait for a digit0 before tracking a frame.
            end
            EXP1: begin
              if (cap_digit == 2'd1) begin
                state <= EXP2;
              end else begin
                seq_error <= 1'b1;
                state     <= SYNC;
              end
            end
            EXP2: begin
              if (cap_digit == 2'd2) begin
                state <= EXP3;
              end else if (cap_digit != 2'd1) begin
                seq_error <= 1'b1;
                state     <= SYNC;
              end
            end
            EXP3: begin
              if (cap_digit == 2'd3) begin
                // The digit3 shadow is written in this same edge, so the
                // decoded value is forwarded directly.
                units_seconds <= shadow[0];
                tens_seconds  <= shadow[1];
                units_minutes <= shadow[2];
                tens_minutes  <= cap_val;
                frame_done    <= 1'b1;
                state         <= SYNC;
              end else if (cap_digit != 2'd2) begin
                seq_error <= 1'b1;
                state     <= SYNC;
              end
            end
            default: state <= SYNC;
          endcase
        end
      end else if (timeout_hit) begin
        stale <= 1'b1;
        state <= SYNC;
      end
    end
  end

endmodule
